np_mem_arbiter: RTL and testbench

- Shares one single-port synchronous memory between two np-family requesters: port A (processor fetch/load/store) and port B (program loader/debug host).
- Runs one transaction at a time, arbitrates round-robin, sequences the fixed memory read latency, and returns read data only to the owning port.
- Sits between the processor's address/dataIn/dataOut/wr interface and the memory macro.

---
 rtl/np_mem_arbiter.sv | 88 ++++++++
 tb/tb_np_mem_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/np_mem_arbiter.sv
// np_mem_arbiter: round-robin sharing of one single-port synchronous memory between ports A and B
module np_mem_arbiter #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12,
    parameter int MEM_LAT  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a_req,
    input  logic                a_wr,
    input  logic [ADDRSIZE-1:0] a_addr,
    input  logic [WIDTH-1:0]    a_wdata,
    output logic                a_gnt,
    output logic                a_rvalid,
    output logic [WIDTH-1:0]    a_rdata,
    input  logic                b_req,
    input  logic                b_wr,
    input  logic [ADDRSIZE-1:0] b_addr,
    input  logic [WIDTH-1:0]    b_wdata,
    output logic                b_gnt,
    output logic                b_rvalid,
    output logic [WIDTH-1:0]    b_rdata,
    output logic                mem_en,
    output logic                mem_wr,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic [WIDTH-1:0]    mem_rdata,
    output logic                busy
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;
    localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

    logic [1:0] state, nxt, cnt;
    logic       last_owner;
    logic       start, pick, done;

    // Arbitration and next state; DONE also samples requests so a new grant can follow the rvalid cycle directly.
    always_comb begin
        start = (state == IDLE || state == DONE) && (a_req || b_req);
        pick  = (a_req && b_req) ? ~last_owner : b_req;
        done  = (state == WAIT) && (cnt == 2'd0);
        nxt   = (state == ISSUE) ? (mem_wr ? IDLE : WAIT) :
                (state == WAIT)  ? (done ? DONE : WAIT) :
                (start ? ISSUE : IDLE);
    end

    // Sequencer state, strobes and per-port read data; last_owner (1 = B) also names the current owner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            last_owner <= 1'b1;
            busy       <= 1'b0;
            a_gnt      <= 1'b0;
            b_gnt      <= 1'b0;
            a_rvalid   <= 1'b0;
            b_rvalid   <= 1'b0;
            mem_en     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            a_rdata    <= '0;
            b_rdata    <= '0;
        end else begin
            state    <= nxt;
            busy     <= nxt != IDLE;
            cnt      <= (state == ISSUE && !mem_wr) ? LAT_M1 : (cnt != 2'd0 ? cnt - 2'd1 : 2'd0);
            a_gnt    <= start && !pick;
            b_gnt    <= start && pick;
            mem_en   <= start;
            mem_wr   <= start && (pick ? b_wr : a_wr);
            a_rvalid <= done && !last_owner;
            b_rvalid <= done && last_owner;
            if (start) begin
                last_owner <= pick;
                mem_addr   <= pick ? b_addr : a_addr;
                mem_wdata  <= pick ? b_wdata : a_wdata;
            end
            if (done && !last_owner)
                a_rdata <= mem_rdata;
            if (done && last_owner)
                b_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_np_mem_arbiter.sv
// tb_np_mem_arbiter: three arbiters (MEM_LAT 1, 2, 4) with latency-accurate memory models, directed and random checks
module tb_np_mem_arbiter;
    localparam int W  = 32;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          a_req [3];
    logic          a_wr [3];
    logic [AW-1:0] a_addr [3];
    logic [W-1:0]  a_wdata [3];
    logic          b_req [3];
    logic          b_wr [3];
    logic [AW-1:0] b_addr [3];
    logic [W-1:0]  b_wdata [3];
    logic          a_gnt [3];
    logic          a_rvalid [3];
    logic [W-1:0]  a_rdata [3];
    logic          b_gnt [3];
    logic          b_rvalid [3];
    logic [W-1:0]  b_rdata [3];
    logic          mem_en [3];
    logic          mem_wr [3];
    logic [AW-1:0] mem_addr [3];
    logic [W-1:0]  mem_wdata [3];
    logic [W-1:0]  mem_rdata [3];
    logic          busy [3];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [W-1:0] ref_mem [int];

    always #5 clk = ~clk;

    function automatic logic [W-1:0] init_word(logic [AW-1:0] a);
        return (a == 12'h010) ? 32'hDEADBEEF : ({a, 4'h0, a, 4'hC} ^ 32'h5A5A_0000);
    endfunction

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 4;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        logic [W-1:0] mem [4096];
        logic [W-1:0] pipe [L];
        if (L < 1 || L > 4) begin : g_bad_lat
            initial $fatal(1, "FAIL cfg MEM_LAT %0d outside 1..4", L);
        end
        initial for (int i = 0; i < 4096; i++) mem[i] = init_word(12'(i));
        always @(posedge clk) begin
            if (mem_en[g] && mem_wr[g]) mem[mem_addr[g]] <= mem_wdata[g];
            pipe[0] <= (mem_en[g] && !mem_wr[g]) ? mem[mem_addr[g]] : {20'hBAD00, cyc[11:0]};
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_rdata[g] = pipe[L-1];
        np_mem_arbiter #(.WIDTH(W), .ADDRSIZE(AW), .MEM_LAT(L)) dut (
            .clk(clk), .reset(reset),
            .a_req(a_req[g]), .a_wr(a_wr[g]), .a_addr(a_addr[g]), .a_wdata(a_wdata[g]),
            .a_gnt(a_gnt[g]), .a_rvalid(a_rvalid[g]), .a_rdata(a_rdata[g]),
            .b_req(b_req[g]), .b_wr(b_wr[g]), .b_addr(b_addr[g]), .b_wdata(b_wdata[g]),
            .b_gnt(b_gnt[g]), .b_rvalid(b_rvalid[g]), .b_rdata(b_rdata[g]),
            .mem_en(mem_en[g]), .mem_wr(mem_wr[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if ({a_gnt[k], b_gnt[k], a_rvalid[k], b_rvalid[k], mem_en[k], mem_wr[k], busy[k]} !== 7'd0) begin
                fails++;
                $display("FAIL reset_ctl[%0d]: got %b exp 0", k, {a_gnt[k], b_gnt[k], a_rvalid[k], b_rvalid[k], mem_en[k], mem_wr[k], busy[k]});
            end
            tests++;
            if ({mem_addr[k], mem_wdata[k], a_rdata[k], b_rdata[k]} !== '0) begin
                fails++;
                $display("FAIL reset_data[%0d]: got %h %h %h %h exp 0", k, mem_addr[k], mem_wdata[k], a_rdata[k], b_rdata[k]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        tests++;
        if ({a_gnt[0], b_gnt[0], mem_en[0], busy[0]} !== 4'd0) begin
            fails++;
            $display("FAIL idle_quiet: got %b exp 0000", {a_gnt[0], b_gnt[0], mem_en[0], busy[0]});
        end
    endtask

    task automatic test_a_read();
        a_wr[0] = 1'b0; a_addr[0] = 12'h010; a_req[0] = 1'b1;
        tick();
        tests++;
        if ({a_gnt[0], b_gnt[0], mem_en[0], mem_wr[0]} !== 4'b1010 || mem_addr[0] !== 12'h010) begin
            fails++;
            $display("FAIL a_read_issue: got %b addr %h exp 1010 addr 010", {a_gnt[0], b_gnt[0], mem_en[0], mem_wr[0]}, mem_addr[0]);
        end
        a_req[0] = 1'b0;
        tick();
        tests++;
        if ({a_gnt[0], a_rvalid[0], b_rvalid[0], mem_en[0], busy[0]} !== 5'b00001) begin
            fails++;
            $display("FAIL a_read_c1: got %b exp 00001", {a_gnt[0], a_rvalid[0], b_rvalid[0], mem_en[0], busy[0]});
        end
        tick();
        tests++;
        if ({a_rvalid[0], b_rvalid[0]} !== 2'b10 || a_rdata[0] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL a_read_c2: got rv %b data %h exp rv 10 data deadbeef", {a_rvalid[0], b_rvalid[0]}, a_rdata[0]);
        end
        tick();
        tests++;
        if ({a_rvalid[0], b_rvalid[0], busy[0]} !== 3'b000 || a_rdata[0] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL a_read_c3: got %b data %h exp 000 data deadbeef", {a_rvalid[0], b_rvalid[0], busy[0]}, a_rdata[0]);
        end
    endtask

    task automatic test_b_write();
        b_wr[0] = 1'b1; b_addr[0] = 12'hFFF; b_wdata[0] = 32'h12345678; b_req[0] = 1'b1;
        tick();
        tests++;
        if ({a_gnt[0], b_gnt[0], mem_en[0], mem_wr[0]} !== 4'b0111 || mem_addr[0] !== 12'hFFF || mem_wdata[0] !== 32'h12345678) begin
            fails++;
            $display("FAIL b_write_issue: got %b addr %h data %h exp 0111 fff 12345678", {a_gnt[0], b_gnt[0], mem_en[0], mem_wr[0]}, mem_addr[0], mem_wdata[0]);
        end
        b_req[0] = 1'b0;
        a_wr[0] = 1'b0; a_addr[0] = 12'hFFF; a_req[0] = 1'b1;
        tick();
        tests++;
        if ({b_gnt[0], a_rvalid[0], b_rvalid[0], mem_en[0], busy[0]} !== 5'd0) begin
            fails++;
            $display("FAIL b_write_c1: got %b exp 00000", {b_gnt[0], a_rvalid[0], b_rvalid[0], mem_en[0], busy[0]});
        end
        tick();
        tests++;
        if (a_gnt[0] !== 1'b1) begin
            fails++;
            $display("FAIL grant_after_write: a_gnt got %b exp 1 at cycle 2", a_gnt[0]);
        end
        a_req[0] = 1'b0;
        tick();
        tick();
        tests++;
        if (a_rvalid[0] !== 1'b1 || a_rdata[0] !== 32'h12345678 || b_rdata[0] !== '0) begin
            fails++;
            $display("FAIL readback_fff: got rv %b a %h b %h exp 1 12345678 0", a_rvalid[0], a_rdata[0], b_rdata[0]);
        end
        tick();
    endtask

    task automatic test_rerequest();
        int pulses = 0;
        int gat[$];
        a_wr[0] = 1'b1; a_addr[0] = 12'h040; a_wdata[0] = $urandom; a_req[0] = 1'b1;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (mem_en[0]) pulses++;
            if (a_gnt[0]) gat.push_back(t);
            if (t == 3) a_req[0] = 1'b0;
        end
        tests++;
        if (pulses != 2) begin
            fails++;
            $display("FAIL rereq_pulses: got %0d exp 2", pulses);
        end
        tests++;
        if (gat.size() != 2 || gat[0] != 0 || gat[1] != 2) begin
            fails++;
            $display("FAIL rereq_cycles: got %p exp '{0, 2}", gat);
        end
    endtask

    task automatic test_fairness();
        int gc[$], gp[$], rc[$], rp[$];
        int pulses = 0;
        logic [W-1:0] rd[$], ed[$];
        a_wr[1] = 1'b0; b_wr[1] = 1'b0; a_addr[1] = 12'h100; b_addr[1] = 12'h180;
        a_req[1] = 1'b1; b_req[1] = 1'b1;
        for (int t = 0; t < 24; t++) begin
            tick();
            if (mem_en[1]) pulses++;
            if (a_gnt[1]) begin gc.push_back(t); gp.push_back(0); ed.push_back(init_word(a_addr[1])); a_addr[1] = a_addr[1] + 12'h1; end
            if (b_gnt[1]) begin gc.push_back(t); gp.push_back(1); ed.push_back(init_word(b_addr[1])); b_addr[1] = b_addr[1] + 12'h1; end
            if (gc.size() >= 4) begin a_req[1] = 1'b0; b_req[1] = 1'b0; end
            if (a_rvalid[1]) begin rc.push_back(t); rp.push_back(0); rd.push_back(a_rdata[1]); end
            if (b_rvalid[1]) begin rc.push_back(t); rp.push_back(1); rd.push_back(b_rdata[1]); end
        end
        tests++;
        if (gc.size() != 4 || rc.size() != 4) begin
            fails++;
            $display("FAIL fair_count: got %0d grants %0d rvalids exp 4 4", gc.size(), rc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (gp[i] != i % 2 || gc[i] != 4 * i) begin
                    fails++;
                    $display("FAIL fair_grant%0d: got port %0d cycle %0d exp port %0d cycle %0d", i, gp[i], gc[i], i % 2, 4 * i);
                end
                tests++;
                if (rp[i] != gp[i] || rc[i] != gc[i] + 3 || rd[i] !== ed[i]) begin
                    fails++;
                    $display("FAIL fair_rvalid%0d: got port %0d cycle %0d data %h exp port %0d cycle %0d data %h", i, rp[i], rc[i], rd[i], gp[i], gc[i] + 3, ed[i]);
                end
            end
        end
        tests++;
        if (pulses != 4) begin
            fails++;
            $display("FAIL fair_mem_en: got %0d pulses exp 4", pulses);
        end
    endtask

    task automatic test_wait_block();
        int ag = -1, ar = -1, bg = -1;
        a_wr[2] = 1'b0; a_addr[2] = 12'h020; a_req[2] = 1'b1;
        for (int t = 0; t < 16; t++) begin
            tick();
            if (a_gnt[2] && ag < 0) begin ag = t; a_req[2] = 1'b0; end
            if (a_rvalid[2] && ar < 0) ar = t;
            if (b_gnt[2] && bg < 0) begin bg = t; b_req[2] = 1'b0; end
            if (t == 2) begin b_wr[2] = 1'b1; b_addr[2] = 12'h030; b_wdata[2] = $urandom; b_req[2] = 1'b1; end
        end
        tests++;
        if (ag != 0 || ar != 5 || bg != 6) begin
            fails++;
            $display("FAIL wait_block: got a_gnt %0d a_rvalid %0d b_gnt %0d exp 0 5 6", ag, ar, bg);
        end
        tests++;
        if (a_rdata[2] !== init_word(12'h020)) begin
            fails++;
            $display("FAIL wait_block_data: got %h exp %h", a_rdata[2], init_word(12'h020));
        end
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        a_wr[2] = 1'b0; a_addr[2] = 12'h050; a_req[2] = 1'b1;
        tick();
        a_req[2] = 1'b0;
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({a_gnt[2], b_gnt[2], a_rvalid[2], b_rvalid[2], mem_en[2], mem_wr[2], busy[2]} !== 7'd0 ||
            {mem_addr[2], mem_wdata[2], a_rdata[2], b_rdata[2]} !== '0) begin
            fails++;
            $display("FAIL abort_async: got ctl %b addr %h a_rdata %h exp all 0", {a_gnt[2], b_gnt[2], a_rvalid[2], b_rvalid[2], mem_en[2], mem_wr[2], busy[2]}, mem_addr[2], a_rdata[2]);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (a_rvalid[2]) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL abort_no_rvalid: got %0d pulses exp 0", seen);
        end
        a_wr[2] = 1'b1; a_addr[2] = 12'h060; a_wdata[2] = $urandom;
        b_wr[2] = 1'b1; b_addr[2] = 12'h070; b_wdata[2] = $urandom;
        a_req[2] = 1'b1; b_req[2] = 1'b1;
        tick();
        tests++;
        if ({a_gnt[2], b_gnt[2]} !== 2'b10) begin
            fails++;
            $display("FAIL abort_favour_a: got %b exp 10", {a_gnt[2], b_gnt[2]});
        end
        a_req[2] = 1'b0;
        tick();
        tick();
        tests++;
        if (b_gnt[2] !== 1'b1) begin
            fails++;
            $display("FAIL abort_then_b: got %b exp 1", b_gnt[2]);
        end
        b_req[2] = 1'b0;
        tick();
        tick();
    endtask

    task automatic new_txn(int k, bit port_b);
        logic [AW-1:0] ad = ($urandom_range(0, 1) ? 12'hFF0 : 12'h800) | 12'($urandom_range(0, 7));
        if (port_b) begin
            b_wr[k] = 1'($urandom_range(0, 1)); b_addr[k] = ad; b_wdata[k] = $urandom; b_req[k] = 1'b1;
        end else begin
            a_wr[k] = 1'($urandom_range(0, 1)); a_addr[k] = ad; a_wdata[k] = $urandom; a_req[k] = 1'b1;
        end
    endtask

    task automatic test_random(int k, int n);
        int lat = lat_of(k);
        int earliest = 0, rv_due = -1, busy_end = -1, key;
        bit last_b = 1'b1, rv_b = 1'b0, eg, win_b, w;
        logic [W-1:0] rv_data = '0, exp_a = '0, exp_b = '0, d;
        logic [AW-1:0] ad;
        a_req[k] = 1'b0; b_req[k] = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            eg = (cyc >= earliest) && (a_req[k] || b_req[k]);
            win_b = (a_req[k] && b_req[k]) ? !last_b : b_req[k];
            tests++;
            if ({a_gnt[k], b_gnt[k], mem_en[k]} !== {eg && !win_b, eg && win_b, eg}) begin
                fails++;
                $display("FAIL rnd%0d_grant cyc %0d: got gnt/en %b exp %b", k, cyc, {a_gnt[k], b_gnt[k], mem_en[k]}, {eg && !win_b, eg && win_b, eg});
            end
            if (eg) begin
                w = win_b ? b_wr[k] : a_wr[k];
                ad = win_b ? b_addr[k] : a_addr[k];
                d = win_b ? b_wdata[k] : a_wdata[k];
                key = k * 4096 + int'(ad);
                tests++;
                if (mem_wr[k] !== w || mem_addr[k] !== ad || (w && mem_wdata[k] !== d)) begin
                    fails++;
                    $display("FAIL rnd%0d_issue cyc %0d: got wr %b addr %h data %h exp wr %b addr %h data %h", k, cyc, mem_wr[k], mem_addr[k], mem_wdata[k], w, ad, d);
                end
                last_b = win_b;
                if (w) begin
                    ref_mem[key] = d;
                    earliest = cyc + 2;
                    busy_end = cyc;
                end else begin
                    rv_due = cyc + 1 + lat;
                    rv_b = win_b;
                    rv_data = ref_mem.exists(key) ? ref_mem[key] : init_word(ad);
                    earliest = cyc + 2 + lat;
                    busy_end = cyc + 1 + lat;
                end
            end
            if (cyc == rv_due) begin
                if (rv_b) exp_b = rv_data;
                else exp_a = rv_data;
            end
            tests++;
            if ({a_rvalid[k], b_rvalid[k]} !== {cyc == rv_due && !rv_b, cyc == rv_due && rv_b}) begin
                fails++;
                $display("FAIL rnd%0d_rvalid cyc %0d: got %b exp %b", k, cyc, {a_rvalid[k], b_rvalid[k]}, {cyc == rv_due && !rv_b, cyc == rv_due && rv_b});
            end
            tests++;
            if (a_rdata[k] !== exp_a || b_rdata[k] !== exp_b) begin
                fails++;
                $display("FAIL rnd%0d_rdata cyc %0d: got %h %h exp %h %h", k, cyc, a_rdata[k], b_rdata[k], exp_a, exp_b);
            end
            tests++;
            if (busy[k] !== (cyc <= busy_end)) begin
                fails++;
                $display("FAIL rnd%0d_busy cyc %0d: got %b exp %b", k, cyc, busy[k], cyc <= busy_end);
            end
            if (a_gnt[k]) begin
                if ($urandom_range(0, 2) == 0) new_txn(k, 1'b0);
                else a_req[k] = 1'b0;
            end else if (!a_req[k] && $urandom_range(0, 1) == 1) new_txn(k, 1'b0);
            if (b_gnt[k]) begin
                if ($urandom_range(0, 2) == 0) new_txn(k, 1'b1);
                else b_req[k] = 1'b0;
            end else if (!b_req[k] && $urandom_range(0, 1) == 1) new_txn(k, 1'b1);
        end
        a_req[k] = 1'b0; b_req[k] = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            a_req[k] = 1'b0; a_wr[k] = 1'b0; a_addr[k] = '0; a_wdata[k] = '0;
            b_req[k] = 1'b0; b_wr[k] = 1'b0; b_addr[k] = '0; b_wdata[k] = '0;
        end
        test_reset();
        test_a_read();
        test_b_write();
        test_rerequest();
        test_fairness();
        test_wait_block();
        test_reset_abort();
        for (int k = 0; k < 3; k++) test_random(k, 300);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
